// File: rtl/cnt_seq_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_seq_chk_pkg
//  Description : Shared types and default parameter values for the counter
//                sequence checker (state encoding, default widths/limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package cnt_seq_chk_pkg;

    localparam int unsigned c_CNT_W  = 10;
    localparam int unsigned c_LOCK_N = 4;
    localparam int unsigned c_ERR_W  = 16;
    localparam int unsigned c_TMO_N  = 1024;

    // Checker state: hunting for a seed, counting matches, or locked
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cnt_seq_chk_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_seq_chk_if
//  Description : Bus bundle between a counter-stream source (master) and the
//                sequence checker (slave). The tmo_pulse signal exists only
//                when CNT_SEQ_CHK_TMO_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cnt_seq_chk_if
    import cnt_seq_chk_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W,
    parameter int unsigned ERR_W = c_ERR_W
) ();

    logic             cnt_vld;
    logic [CNT_W-1:0] cnt_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [CNT_W-1:0] exp_cnt;

`ifdef CNT_SEQ_CHK_TMO_EN
    logic             tmo_pulse;

    modport master (
        output cnt_vld, cnt_in,
        input  locked, err_pulse, err_cnt, exp_cnt, tmo_pulse
    );

    modport slave (
        input  cnt_vld, cnt_in,
        output locked, err_pulse, err_cnt, exp_cnt, tmo_pulse
    );
`else
    modport master (
        output cnt_vld, cnt_in,
        input  locked, err_pulse, err_cnt, exp_cnt
    );

    modport slave (
        input  cnt_vld, cnt_in,
        output locked, err_pulse, err_cnt, exp_cnt
    );
`endif

endinterface
`default_nettype wire

// File: rtl/cnt_seq_chk_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt
//  Description : Parameterised saturating up-counter with synchronous clear.
//                Clear wins over increment; the count sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, else increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cnt_seq_chk.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_seq_chk
//  Description : Receive-side checker for a free-running counter stream.
//                Seeds on the first valid sample, locks after LOCK_N
//                consecutive +1 samples, then flags every break with a
//                one-cycle err_pulse and a saturating error tally.
//                Optional idle timeout: define CNT_SEQ_CHK_TMO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_seq_chk
    import cnt_seq_chk_pkg::*;
#(
    parameter int unsigned CNT_W  = c_CNT_W,
    parameter int unsigned LOCK_N = c_LOCK_N,
    parameter int unsigned ERR_W  = c_ERR_W,
    parameter int unsigned TMO_N  = c_TMO_N
) (
    input  wire logic       sclk,
    input  wire logic       rst,
    cnt_seq_chk_if.slave    bus
);

    localparam int unsigned c_RUN_W = $clog2(LOCK_N + 1);

    // Reject configurations the lock / timeout logic cannot honour
    if ((LOCK_N < 1) || (TMO_N < 1)) begin : g_param_chk
        $error("cnt_seq_chk: LOCK_N and TMO_N must both be >= 1");
    end

    state_t             state_q,     state_d;
    logic [c_RUN_W-1:0] run_q,       run_d;
    logic [CNT_W-1:0]   exp_q,       exp_d;
    logic               locked_q,    locked_d;
    logic               err_pulse_q, err_pulse_d;

    logic               w_match;
    logic [CNT_W-1:0]   w_nxt;
    logic               w_err_inc;
    logic               w_tmo;
    logic [ERR_W-1:0]   w_err_cnt;

    assign w_match = (bus.cnt_in == exp_q);
    // Natural CNT_W-bit wrap makes all-ones followed by zero a match
    assign w_nxt   = bus.cnt_in + 1'b1;

`ifdef CNT_SEQ_CHK_TMO_EN
    localparam int unsigned c_IDLE_W = $clog2(TMO_N + 1);

    logic                w_idle_inc;
    logic                w_idle_clr;
    logic [c_IDLE_W-1:0] w_idle_cnt;
    logic                tmo_pulse_q, tmo_pulse_d;

    // Idle cycles only count while a sequence is being tracked
    assign w_idle_inc = !bus.cnt_vld && (state_q != HUNT);
    assign w_idle_clr = bus.cnt_vld || (state_q == HUNT);
    // Fires on the edge that completes the TMO_N-th consecutive idle cycle
    assign w_tmo      = w_idle_inc && (w_idle_cnt == c_IDLE_W'(TMO_N - 1));
    assign tmo_pulse_d = w_tmo;

    sat_cnt #(
        .WIDTH (c_IDLE_W)
    ) u_idle_cnt (
        .clk   (sclk),
        .rst   (rst),
        .i_clr (w_idle_clr),
        .i_inc (w_idle_inc),
        .o_cnt (w_idle_cnt)
    );

    // Timeout pulse register
    always_ff @(posedge sclk) begin
        if (rst) begin
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign bus.tmo_pulse = tmo_pulse_q;
`else
    assign w_tmo = 1'b0;
`endif

    // Next-state and output decode; every valid sample reseeds exp_cnt
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        exp_d       = exp_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        w_err_inc   = 1'b0;

        if (bus.cnt_vld) begin
            exp_d = w_nxt;
            case (state_q)
                HUNT: begin
                    run_d   = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (w_match) begin
                        run_d = run_q + 1'b1;
                        if (run_q == c_RUN_W'(LOCK_N - 1)) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        // Mismatch before lock simply restarts the run
                        run_d = '0;
                    end
                end
                LOCK: begin
                    if (!w_match) begin
                        err_pulse_d = 1'b1;
                        w_err_inc   = 1'b1;
                        locked_d    = 1'b0;
                        run_d       = '0;
                        state_d     = SYNC;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end else if (w_tmo) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            run_d    = '0;
        end
    end

    // State and registered-output flops
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= HUNT;
            run_q       <= '0;
            exp_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            exp_q       <= exp_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_cnt #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (sclk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_err_inc),
        .o_cnt (w_err_cnt)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = w_err_cnt;
    assign bus.exp_cnt   = exp_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_seq_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_seq_chk
//  Description : Self-checking bench for cnt_seq_chk. A stream-level model
//                (seed / streak / error tally) predicts every output each
//                cycle; directed scenarios are followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_seq_chk;

    localparam int CNT_W   = 10;
    localparam int LOCK_N  = 4;
    localparam int ERR_W   = 4;
    localparam int TMO_N   = 8;
    localparam int MOD     = 1 << CNT_W;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic sclk = 1'b0;
    logic rst  = 1'b1;

    always #5 sclk = ~sclk;

    cnt_seq_chk_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    cnt_seq_chk #(
        .CNT_W  (CNT_W),
        .LOCK_N (LOCK_N),
        .ERR_W  (ERR_W),
        .TMO_N  (TMO_N)
    ) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    // Reference model state: stream-level view, not the FSM encoding
    bit m_seeded;
    bit m_locked;
    bit m_pulse;
    bit m_tmo;
    int m_exp;
    int m_streak;
    int m_errs;
    int m_idle;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int val);
        m_pulse = 1'b0;
        m_tmo   = 1'b0;
        if (r) begin
            m_seeded = 1'b0;
            m_locked = 1'b0;
            m_exp    = 0;
            m_streak = 0;
            m_errs   = 0;
            m_idle   = 0;
        end else if (v) begin
            m_idle = 0;
            if (!m_seeded) begin
                m_seeded = 1'b1;
                m_streak = 0;
            end else if (val == m_exp) begin
                m_streak++;
                if (m_streak >= LOCK_N) m_locked = 1'b1;
            end else begin
                if (m_locked) begin
                    m_errs++;
                    m_pulse  = 1'b1;
                    m_locked = 1'b0;
                end
                m_streak = 0;
            end
            m_exp = (val + 1) % MOD;
        end else begin
`ifdef CNT_SEQ_CHK_TMO_EN
            if (m_seeded) begin
                m_idle++;
                if (m_idle == TMO_N) begin
                    m_tmo    = 1'b1;
                    m_seeded = 1'b0;
                    m_locked = 1'b0;
                    m_idle   = 0;
                end
            end
`endif
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge
    task automatic cyc(input bit r, input bit v, input int val);
        int e;
        @(negedge sclk);
        rst         = r;
        bus.cnt_vld = v;
        bus.cnt_in  = CNT_W'(val);
        @(posedge sclk);
        model_step(r, v, val);
        #1;
        e = (m_errs > ERR_MAX) ? ERR_MAX : m_errs;
        chk("locked",    int'(bus.locked),    int'(m_locked));
        chk("err_pulse", int'(bus.err_pulse), int'(m_pulse));
        chk("err_cnt",   int'(bus.err_cnt),   e);
        chk("exp_cnt",   int'(bus.exp_cnt),   m_exp);
`ifdef CNT_SEQ_CHK_TMO_EN
        chk("tmo_pulse", int'(bus.tmo_pulse), int'(m_tmo));
`endif
    endtask

    task automatic feed(input int val);
        cyc(1'b0, 1'b1, val % MOD);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 0);
    endtask

    initial begin
        bus.cnt_vld = 1'b0;
        bus.cnt_in  = '0;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_exp",    int'(bus.exp_cnt), 0);

        // Acquire lock on 0..5
        for (int v = 0; v <= 5; v++) begin
            feed(v);
            if (v == 3) chk("tp1_not_yet_locked", int'(bus.locked), 0);
            if (v == 4) chk("tp1_locked", int'(bus.locked), 1);
        end
        chk("tp1_exp6", int'(bus.exp_cnt), 6);
        chk("tp1_no_err", int'(bus.err_cnt), 0);

        // Wrap through 1023 -> 0 while locked
        do_reset();
        for (int v = 1017; v <= 1021; v++) feed(v);
        feed(1022); feed(1023); feed(0); feed(1);
        chk("tp2_locked", int'(bus.locked), 1);
        chk("tp2_exp2",   int'(bus.exp_cnt), 2);
        chk("tp2_no_err", int'(bus.err_cnt), 0);

        // Break at 13 while locked, then relock on 14..17
        do_reset();
        for (int v = 6; v <= 11; v++) feed(v);
        feed(13);
        chk("tp3_pulse",  int'(bus.err_pulse), 1);
        chk("tp3_errcnt", int'(bus.err_cnt), 1);
        chk("tp3_unlock", int'(bus.locked), 0);
        chk("tp3_exp14",  int'(bus.exp_cnt), 14);
        feed(14);
        chk("tp3_pulse_one_cycle", int'(bus.err_pulse), 0);
        feed(15); feed(16); feed(17);
        chk("tp3_relock", int'(bus.locked), 1);

        // Valid toggling while locked
        feed(18); feed(19);
        feed(20); idle(); feed(21); idle(); feed(22); idle();
        chk("tp4_locked", int'(bus.locked), 1);
        chk("tp4_errs",   int'(bus.err_cnt), 1);

        // Back-to-back mismatches: one error only
        feed(500); feed(700);
        chk("b2b_one_err", int'(bus.err_cnt), 2);
        for (int v = 701; v <= 704; v++) feed(v);
        feed(300);
        chk("tp5_err3", int'(bus.err_cnt), 3);
        for (int v = 301; v <= 304; v++) feed(v);
        do_reset();
        chk("tp5_rst_locked", int'(bus.locked), 0);
        chk("tp5_rst_err",    int'(bus.err_cnt), 0);
        chk("tp5_rst_exp",    int'(bus.exp_cnt), 0);

        // Saturation of the error tally
        for (int i = 0; i < ERR_MAX + 4; i++) begin
            for (int k = 0; k <= LOCK_N; k++) feed(i * 40 + k);
        end
        feed(1000);
        chk("sat_err", int'(bus.err_cnt), ERR_MAX);

`ifdef CNT_SEQ_CHK_TMO_EN
        // Idle timeout after lock
        do_reset();
        for (int v = 0; v <= LOCK_N; v++) feed(v);
        for (int i = 0; i < TMO_N - 1; i++) idle();
        chk("tmo_not_yet", int'(bus.tmo_pulse), 0);
        idle();
        chk("tmo_pulse", int'(bus.tmo_pulse), 1);
        chk("tmo_unlock", int'(bus.locked), 0);
        idle();
        chk("tmo_pulse_one_cycle", int'(bus.tmo_pulse), 0);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                cyc(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)));
            end else if ($urandom_range(0, 99) == 0) begin
                for (int k = 0; k < 10; k++) idle();
            end else if ($urandom_range(0, 3) == 0) begin
                idle();
            end else if ($urandom_range(0, 19) == 0) begin
                feed(int'($urandom_range(0, MOD - 1)));
            end else begin
                feed(m_exp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cnt_seq_chk.md
Name: cnt_seq_chk

Overview:
- Receive-side checker for the free-running counter stream produced by the counter block.
- Samples a qualified count value and verifies that each sample equals the previous one +1, modulo 2^CNT_W.
- Acquires lock, then reports discontinuities and keeps a saturating error tally.
- Sits on the consumer side of any link that carries the counter, for on-board self-test and as a bench monitor.

Parameters:
- CNT_W, 10, width of the incoming count, wraps modulo 2^CNT_W
- LOCK_N, 4, consecutive matching samples after the seed sample needed to declare lock, must be >= 1
- ERR_W, 16, width of the saturating error counter
- TMO_N, 1024, idle-cycle limit, used only with the optional feature

Ports:
- sclk, input, 1, system clock, all logic on rising edge
- rst, input, 1, synchronous active-high reset
- cnt_vld, input, 1, cnt_in is valid this cycle
- cnt_in, input, CNT_W, received count value
- locked, output, 1, checker is locked to the sequence
- err_pulse, output, 1, one-cycle pulse on a sequence break while locked
- err_cnt, output, ERR_W, saturating count of sequence breaks
- exp_cnt, output, CNT_W, next expected value
- tmo_pulse, output, 1, idle-timeout pulse; exists only when CNT_SEQ_CHK_TMO_EN is defined

Behaviour:
- Interface: one clock, sclk. Reset is synchronous and active-high on rst.
- Reset: while rst=1 at a sclk edge, the next state is:
  - state HUNT, run counter 0
  - locked 0, err_pulse 0, err_cnt 0, exp_cnt 0, tmo_pulse 0
- Reset has priority over every other event, including in mid-lock and mid-sync.
- Samples:
  - Only cycles with cnt_vld=1 are samples.
  - With cnt_vld=0, state, run, exp_cnt and err_cnt hold, and err_pulse is 0.
- Match: cnt_in == exp_cnt. exp_cnt update is always cnt_in + 1, truncated to CNT_W bits, so 2^CNT_W-1 is followed by 0 without error.
- FSM, all outputs registered:
  - HUNT: on the first sample, exp_cnt <= cnt_in+1, run <= 0, go to SYNC.
  - SYNC, match: run++. When run reaches LOCK_N, go to LOCK and locked <= 1.
  - SYNC, mismatch: reseed with exp_cnt <= cnt_in+1 and run <= 0, stay in SYNC. No error is counted.
  - LOCK, match: stay in LOCK.
  - LOCK, mismatch:
    - err_pulse <= 1 for exactly one cycle
    - err_cnt <= err_cnt+1, saturating at 2^ERR_W-1
    - locked <= 0
    - exp_cnt <= cnt_in+1, run <= 0
    - go to SYNC
- Latency: locked, err_pulse and exp_cnt change on the sclk edge that captures the sample, and are visible in the following cycle.
- Back-to-back mismatches in LOCK yield exactly one error. The checker is already in SYNC for the second mismatch.
- run width is clog2(LOCK_N+1).

Optional Feature:
- Macro: CNT_SEQ_CHK_TMO_EN
- Defined:
  - An idle counter counts consecutive cycles with cnt_vld=0 while in LOCK or SYNC. It clears on any sample.
  - When it reaches TMO_N: tmo_pulse <= 1 for one cycle, state <= HUNT, locked <= 0. err_cnt is unchanged.
  - The idle counter is held at 0 in HUNT.
- Not defined:
  - No idle counter and no tmo_pulse port.
  - The checker waits indefinitely with lock held.

Decomposition:
- Package cnt_seq_chk_pkg holds:
  - state enum {HUNT, SYNC, LOCK}, 2 bits
  - default parameter constants
- One sub-module, sat_cnt: a parameterised saturating incrementer with synchronous clear. It is used for err_cnt and, when enabled, for the idle counter.

Test Plan:
- Reset, then cnt_in=0..5 with cnt_vld=1 every cycle -> locked=1 in the cycle after sample 4 is captured; err_cnt=0; exp_cnt=6 after sample 5.
- Locked at 1021, then feed 1022, 1023, 0, 1 -> no err_pulse, locked stays 1, exp_cnt=2.
- Locked, feed 10, 11, 13 -> one-cycle err_pulse after 13, err_cnt=1, locked=0, exp_cnt=14. Then 14, 15, 16, 17 -> relock.
- Locked, cnt_vld toggled 1/0 with values 20, 21, 22 on the valid cycles only -> locked stays 1, no errors.
- Locked with err_cnt=3, assert rst for one cycle -> next cycle locked=0, err_cnt=0, exp_cnt=0, state HUNT.
- ERR_W=2, five lock-and-break cycles -> err_cnt=3 (saturated). With the macro defined and TMO_N=8: locked, then 8 idle cycles -> tmo_pulse, locked=0.
